trapezoid_integ_ctrl: RTL and testbench

TRAPEZOID_INTEG_CTRL -- requirements
Module: trapezoid_integ_ctrl

---
 rtl/trapezoid_integ_ctrl_if.sv | 31 +++
 rtl/trapezoid_integ_ctrl.sv | 160 ++++++++++++++++
 tb/tb_trapezoid_integ_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trapezoid_integ_ctrl_if.sv
// Bundles the sample stream, calculator handshake and run status of the trapezoid integrator.
// The slave modport is the controller; the master modport is its environment (sample source and calculator).
interface trapezoid_integ_ctrl_if #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] seg_cnt;
    logic [15:0]      s_data;
    logic             s_valid;
    logic             s_ready;
    logic             calc_en;
    logic [15:0]      calc_a;
    logic [15:0]      calc_b;
    logic [31:0]      calc_surf;
    logic             calc_valid;
    logic             busy;
    logic [ACC_W-1:0] result;
    logic             done;
    logic             ovf;

    modport slave (
        input  start, seg_cnt, s_data, s_valid, calc_surf, calc_valid,
        output s_ready, calc_en, calc_a, calc_b, busy, result, done, ovf
    );

    modport master (
        output start, seg_cnt, s_data, s_valid, calc_surf, calc_valid,
        input  s_ready, calc_en, calc_a, calc_b, busy, result, done, ovf
    );
endinterface

// File: rtl/trapezoid_integ_ctrl.sv
// Trapezoid integrator controller: pairs consecutive samples, issues them to a surface calculator, accumulates.
// Latency: done/result two cycles after the last calc_valid (one cycle through DONE); N=0 finishes 2 cycles after start.
// Backpressure: s_ready only in LOAD/FEED, one sample per calculator round trip. TRAP_INTEG_SAT_EN selects saturation.
module trapezoid_integ_ctrl #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
) (
    input logic                      clk,
    input logic                      rst,
    trapezoid_integ_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic [15:0]      prev_q, prev_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             s_ready_c;
    logic             calc_en_c;
    logic             xfer;
    logic [ACC_W-1:0] surf_ext;

    // Size cast zero-extends for wide accumulators and keeps the low bits for narrow ones.
    assign surf_ext = ACC_W'(bus.calc_surf);
    assign xfer     = bus.s_valid & s_ready_c;

`ifdef TRAP_INTEG_SAT_EN
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, surf_ext};
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        result_d  = result_q;
        prev_d    = prev_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        s_ready_c = 1'b0;
        calc_en_c = 1'b0;
`ifdef TRAP_INTEG_SAT_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    rem_d   = bus.seg_cnt;
`ifdef TRAP_INTEG_SAT_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = (bus.seg_cnt == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                s_ready_c = 1'b1;
                if (xfer) begin
                    prev_d  = bus.s_data;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                s_ready_c = 1'b1;
                if (xfer) begin
                    a_d     = prev_q;
                    b_d     = bus.s_data;
                    prev_d  = bus.s_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                calc_en_c = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.calc_valid) begin
`ifdef TRAP_INTEG_SAT_EN
                    if (sum[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
`else
                    acc_d = acc_q + surf_ext;
`endif
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_FEED;
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                result_d = acc_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            result_q <= '0;
            prev_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            prev_q   <= prev_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            done_q   <= done_d;
        end
    end

`ifdef TRAP_INTEG_SAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.s_ready = s_ready_c;
    assign bus.calc_en = calc_en_c;
    assign bus.calc_a  = a_q;
    assign bus.calc_b  = b_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.result  = result_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_trapezoid_integ_ctrl.sv
// Bench for trapezoid_integ_ctrl: a 48-bit and a 21-bit instance share one sample stream, each with its own calculator.
// Expected calculator pairs and results are queued at stimulus time and popped when calc_en / done appear.
module tb_trapezoid_integ_ctrl;

    logic clk;
    logic rst_n;

    trapezoid_integ_ctrl_if #(.ACC_W(48), .CNT_W(16)) if48 ();
    trapezoid_integ_ctrl_if #(.ACC_W(21), .CNT_W(16)) if21 ();

    trapezoid_integ_ctrl #(.ACC_W(48), .CNT_W(16)) dut48 (.clk(clk), .rst(rst_n), .bus(if48.slave));
    trapezoid_integ_ctrl #(.ACC_W(21), .CNT_W(16)) dut21 (.clk(clk), .rst(rst_n), .bus(if21.slave));

    assign if21.start   = if48.start;
    assign if21.seg_cnt = if48.seg_cnt;
    assign if21.s_data  = if48.s_data;
    assign if21.s_valid = if48.s_valid;

    // Downstream calculators: registered (a+b)<<3, valid one cycle after calc_en.
    always @(posedge clk) begin
        if48.calc_valid <= (if48.calc_en === 1'b1);
        if48.calc_surf  <= ({16'd0, if48.calc_a} + {16'd0, if48.calc_b}) << 3;
        if21.calc_valid <= (if21.calc_en === 1'b1);
        if21.calc_surf  <= ({16'd0, if21.calc_a} + {16'd0, if21.calc_b}) << 3;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] samp [0:7];
    logic [31:0] pair_q [$];
    logic [47:0] res48_q [$];
    logic [20:0] res21_q [$];
    logic        ovf21_q [$];
    logic [47:0] last48 = '0;
    logic [20:0] last21 = '0;

    task automatic run(input int n, input int gap, input int stray, input string name);
        logic [63:0] sum;
        logic [20:0] e21;
        logic        eo21;
        logic [31:0] p;
        logic [31:0] last_pair;
        logic        xfer;
        int idx, gapc, ndone, done_k, bad;
        pair_q.delete(); res48_q.delete(); res21_q.delete(); ovf21_q.delete();
        sum = '0;
        last_pair = '0;
        for (int i = 0; i < n; i++) begin
            pair_q.push_back({samp[i], samp[i+1]});
            sum = sum + 64'(({16'd0, samp[i]} + {16'd0, samp[i+1]}) << 3);
        end
        samp[n+1] = 16'hDEAD;
`ifdef TRAP_INTEG_SAT_EN
        if (sum > 64'h1FFFFF) begin
            e21 = 21'h1FFFFF; eo21 = 1'b1;
        end else begin
            e21 = sum[20:0]; eo21 = 1'b0;
        end
`else
        e21 = sum[20:0]; eo21 = 1'b0;
`endif
        res48_q.push_back(sum[47:0]);
        res21_q.push_back(e21);
        ovf21_q.push_back(eo21);

        @(posedge clk); #1;
        checks++;
        if ({if48.result, if21.result} !== {last48, last21}) begin
            errors++;
            $display("FAIL %s result_hold got %h/%h want %h/%h", name, if48.result, if21.result, last48, last21);
        end
        if48.start   = 1'b1;
        if48.seg_cnt = 16'(n);
        if48.s_valid = 1'b1;
        if48.s_data  = samp[0];
        idx = 0; gapc = 0; ndone = 0; done_k = -1; bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (if48.calc_en) begin
                checks++;
                if (pair_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_calc_en got a=%h b=%h want none", name, if48.calc_a, if48.calc_b);
                end else begin
                    p = pair_q.pop_front();
                    last_pair = p;
                    if ({if48.calc_a, if48.calc_b} !== p) begin
                        errors++;
                        $display("FAIL %s calc_pair got %h,%h want %h,%h", name, if48.calc_a, if48.calc_b, p[31:16], p[15:0]);
                    end
                end
            end
            if (if48.s_ready || if48.calc_en) bad = 1;
            if (if48.done) begin
                ndone++;
                done_k = k;
                checks++;
                if (res48_q.size() == 0 || {if21.done, if48.result, if48.ovf} !== {1'b1, res48_q[0], 1'b0}) begin
                    errors++;
                    $display("FAIL %s result48 got %h ovf %b want %h ovf 0", name, if48.result, if48.ovf, sum[47:0]);
                end
                checks++;
                if (res21_q.size() == 0 || {if21.result, if21.ovf} !== {res21_q[0], ovf21_q[0]}) begin
                    errors++;
                    $display("FAIL %s result21 got %h ovf %b want %h ovf %b", name, if21.result, if21.ovf, e21, eo21);
                end
                if (res48_q.size() != 0) begin
                    void'(res48_q.pop_front()); void'(res21_q.pop_front()); void'(ovf21_q.pop_front());
                end
                if (n > 0) begin
                    checks++;
                    if ({if48.calc_a, if48.calc_b} !== last_pair) begin
                        errors++;
                        $display("FAIL %s calc_hold got %h,%h want %h", name, if48.calc_a, if48.calc_b, last_pair);
                    end
                end
            end
            if (ndone > 0 && k >= done_k + 3) break;
            xfer = if48.s_valid && if48.s_ready;
            @(posedge clk); #1;
            if (k == stray) begin
                if48.start = 1'b1; if48.seg_cnt = 16'd0;
            end else begin
                if48.start = 1'b0;
            end
            if (xfer) begin
                idx++; gapc = gap; if48.s_valid = 1'b0;
            end
            if (!if48.s_valid && idx < n + 2) begin
                if (gapc == 0) begin
                    if48.s_valid = 1'b1; if48.s_data = samp[idx];
                end else begin
                    gapc--;
                end
            end
        end
        if48.s_valid = 1'b0;
        if48.start   = 1'b0;
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL %s done_count got %0d want 1", name, ndone);
        end
        checks++;
        if (idx != ((n == 0) ? 0 : n + 1) || pair_q.size() != 0) begin
            errors++;
            $display("FAIL %s samples_used got %0d (pairs left %0d) want %0d", name, idx, pair_q.size(), (n == 0) ? 0 : n + 1);
        end
        if (n == 0) begin
            checks++;
            if (bad != 0 || done_k != 2) begin
                errors++;
                $display("FAIL %s zero_run got handshake %0d done_cycle %0d want 0 and 2", name, bad, done_k);
            end
        end
        checks++;
        if ({if48.busy, if21.busy} !== 2'b00) begin
            errors++;
            $display("FAIL %s busy_after got %b%b want 00", name, if48.busy, if21.busy);
        end
        last48 = sum[47:0];
        last21 = e21;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if48.start = 1'b0; if48.seg_cnt = '0; if48.s_valid = 1'b0; if48.s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if48.s_ready, if48.calc_en, if48.busy, if48.done, if48.ovf, if48.calc_a, if48.calc_b, if48.result, if21.result} !== '0) begin
            errors++;
            $display("FAIL reset_values got rdy%b en%b busy%b done%b ovf%b a%h b%h r%h r21%h want all 0",
                     if48.s_ready, if48.calc_en, if48.busy, if48.done, if48.ovf, if48.calc_a, if48.calc_b, if48.result, if21.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        samp[0] = 16'd3; samp[1] = 16'd5;
        run(1, 0, -1, "single");
    endtask

    task automatic test_multi();
        samp[0] = 16'd1; samp[1] = 16'd2; samp[2] = 16'd3; samp[3] = 16'd4;
        run(3, 0, -1, "multi");
    endtask

    task automatic test_zero();
        samp[0] = 16'd7;
        run(0, 0, -1, "zero");
    endtask

    task automatic test_gaps();
        samp[0] = 16'd10; samp[1] = 16'd20; samp[2] = 16'd30;
        run(2, 3, 5, "gaps");
    endtask

    task automatic test_sat();
        for (int i = 0; i < 4; i++) samp[i] = 16'hFFFF;
        run(3, 0, -1, "sat");
    endtask

    task automatic test_back_to_back();
        samp[0] = 16'd100; samp[1] = 16'd200; samp[2] = 16'd50;
        run(2, 0, -1, "b2b_a");
        samp[0] = 16'd9; samp[1] = 16'd1;
        run(1, 1, -1, "b2b_b");
    endtask

    task automatic test_mid_reset();
        logic xfer;
        int idx, seen;
        samp[0] = 16'd1; samp[1] = 16'd2; samp[2] = 16'd3; samp[3] = 16'd4;
        @(posedge clk); #1;
        if48.start = 1'b1; if48.seg_cnt = 16'd3; if48.s_valid = 1'b1; if48.s_data = samp[0];
        idx = 0; seen = 0;
        for (int k = 0; k < 50 && seen == 0; k++) begin
            @(negedge clk);
            if (if48.calc_en) seen = 1;
            xfer = if48.s_valid && if48.s_ready;
            @(posedge clk); #1;
            if48.start = 1'b0;
            if (xfer) begin
                idx++; if48.s_data = samp[idx];
            end
        end
        if48.s_valid = 1'b0;
        checks++;
        if (seen == 0 || {if48.busy, if48.calc_a, if48.calc_b} !== {1'b1, 16'd1, 16'd2}) begin
            errors++;
            $display("FAIL midrst_issue got seen%0d busy%b a%h b%h want 1 1 1 2", seen, if48.busy, if48.calc_a, if48.calc_b);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if48.s_ready, if48.calc_en, if48.busy, if48.done, if48.ovf, if48.calc_a, if48.calc_b, if48.result, if21.busy} !== '0) begin
            errors++;
            $display("FAIL midrst_values got rdy%b en%b busy%b done%b ovf%b a%h b%h r%h want all 0",
                     if48.s_ready, if48.calc_en, if48.busy, if48.done, if48.ovf, if48.calc_a, if48.calc_b, if48.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({if48.done, if48.busy, if48.result, if21.done} !== '0) begin
                errors++;
                $display("FAIL midrst_quiet got done%b busy%b r%h want 0 0 0", if48.done, if48.busy, if48.result);
            end
        end
        last48 = '0;
        last21 = '0;
        samp[0] = 16'd3; samp[1] = 16'd5;
        run(1, 0, -1, "after_rst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_zero();
        test_gaps();
        test_sat();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
